// File: rtl/dmem_pkg.sv
// =============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the dmem_responder slice.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    localparam logic        ERR_NONE   = 1'b0;
    localparam logic        ERR_FAULT  = 1'b1;
    localparam logic [31:0] RDATA_IDLE = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// =============================================================================
// Module      : dmem_array
// Description : Single-port word storage, byte-enabled synchronous write,
//               combinational read. Contents are never reset.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [WORD_BYTES-1:0] i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// Module      : dmem_responder
// Description : Wait-stated data-memory responder with req/ack handshake.
//               Optional macro DMEM_MISALIGN_ERR_EN flags addr[1:0]!=0 as error.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int c_aw    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load =
        (WAIT_CYCLES > 0) ? c_cnt_w'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic c_misalign_en = 1'b1;
`else
    localparam logic c_misalign_en = 1'b0;
`endif

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_latch;

    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;

    logic                 w_cur_we;
    logic [31:0]          w_cur_addr;
    logic [31:0]          w_cur_wdata;
    logic [3:0]           w_cur_be;
    logic [29:0]          w_cur_idx;
    logic                 w_err;
    logic                 w_mem_we;
    logic [31:0]          w_mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero wait states the store commits on the sampling edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    assign w_cur_we    = (r_state == IDLE) ? we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? be    : r_be;
    assign w_cur_idx   = w_cur_addr[31:2];

    assign w_err = ({2'b00, w_cur_idx} >= c_depth) ||
                   (c_misalign_en && (w_cur_addr[1:0] != 2'b00));

    assign w_mem_we = (w_state_nxt == RESP) && (r_state != RESP) &&
                      w_cur_we && !w_err && !rst;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_aw)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_cur_idx[c_aw-1:0]),
        .i_be    (w_cur_be),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ack   = (r_state == RESP);
    assign err   = (ack && w_err) ? ERR_FAULT : ERR_NONE;
    assign rdata = (ack && !r_we && !w_err) ? w_mem_rdata : RDATA_IDLE;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the storage depth in 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states inserted before the response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 1 bit: the requester holds it high with stable we/addr/wdata/be until ack.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address; the word index is addr[31:2].
REQ-008 The block SHALL have port wdata, input, 32 bits: store data.
REQ-009 The block SHALL have port be, input, 4 bits: store byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rdata, output, 32 bits: load data, valid only while ack is high.
REQ-012 The block SHALL have port err, output, 1 bit: error flag, valid only while ack is high.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 the block SHALL latch we/addr/wdata/be and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded with WAIT_CYCLES-1, then go to RESP.
REQ-016 ack SHALL rise WAIT_CYCLES+1 cycles after the edge that sampled req.
REQ-017 RESP SHALL drive ack=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-018 If req is still high in IDLE after RESP, the block SHALL treat it as a new request (back-to-back period WAIT_CYCLES+2).
REQ-019 Input changes during WAIT or RESP SHALL be ignored; only latched values are used.
REQ-020 A store SHALL commit to storage on the edge entering RESP, writing only the lanes with be set; be=4'b0000 SHALL be acked without modifying storage.
REQ-021 A load SHALL return the full word at the latched index regardless of be.
REQ-022 When ack=0, rdata SHALL be 0 and err SHALL be 0.
REQ-023 A word index >= DEPTH_WORDS SHALL suppress the store, return rdata=0, and assert err=1 with ack.
REQ-024 Storage contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL enter IDLE with ack=0, rdata=0, err=0 and counter=0.
REQ-026 A reset during WAIT SHALL abort the access with no store committed and no ack.
REQ-027 A reset during RESP SHALL keep the already-committed store but force ack=0 from the next cycle.
REQ-028 A req held high across the release of reset SHALL be sampled on the first edge with rst=0.

Configuration
REQ-029 With DMEM_MISALIGN_ERR_EN defined, a request with addr[1:0]!=0 SHALL be acked with err=1, rdata=0 and no store.
REQ-030 Without DMEM_MISALIGN_ERR_EN, addr[1:0] SHALL be ignored.
REQ-031 In both configurations the latency SHALL be identical.

Structure
REQ-032 The package dmem_pkg SHALL hold the state enumeration, WORD_BYTES=4 and the error/response-field constants.
REQ-033 Storage SHALL be a sub-module dmem_array: single-port, synchronous write with per-byte enables, combinational read.

Verification
REQ-034 The bench SHALL cover: WAIT_CYCLES=2, store addr=0x10, wdata=0xDEADBEEF, be=4'hF -> ack 3 cycles after req sampled, err=0; a following load of 0x10 returns 0xDEADBEEF.
REQ-035 The bench SHALL cover: store addr=0x10, wdata=0x000000AA, be=4'b0001 over 0xDEADBEEF -> a following load returns 0xDEADBEAA.
REQ-036 The bench SHALL cover: load addr=0x400 with DEPTH_WORDS=256 -> ack with err=1, rdata=0; a store there is ignored.
REQ-037 The bench SHALL cover: req held high for 10 cycles with WAIT_CYCLES=0 -> ack pulses every 2 cycles, 5 pulses total.
REQ-038 The bench SHALL cover: store to 0x20 with rst=1 asserted in the second WAIT cycle -> no ack, and a following load of 0x20 returns the prior value.
REQ-039 The bench SHALL cover: addr=0x13 load -> err=1 with DMEM_MISALIGN_ERR_EN defined, and the word at 0x10 with it undefined.
